// File: rtl/pipeline_flow_controller_if.sv
// Pipeline hazard/flow-control bundle: event inputs from the datapath and
// memories, and stall/clear controls plus status back to the pipeline.
interface pipeline_flow_controller_if;
   logic        pc_valid;
   logic        imem_ready;
   logic        dmem_busy;
   logic        load_use_hazard;
   logic        branch_taken;
   logic        jump_decode;

   logic        stall_programe_counter_stage;
   logic        stall_instruction_fetch_stage;
   logic        stall_decoding_stage;
   logic        stall_execution_stage;
   logic        clear_instruction_fetch_stage;
   logic        clear_decoding_stage;
   logic        clear_execution_stage;
   logic [15:0] stall_count;
   logic [1:0]  fsm_state;

   // Controller side: consumes events, produces stall/clear controls.
   modport master (
      input  pc_valid, imem_ready, dmem_busy, load_use_hazard, branch_taken, jump_decode,
      output stall_programe_counter_stage, stall_instruction_fetch_stage,
             stall_decoding_stage, stall_execution_stage,
             clear_instruction_fetch_stage, clear_decoding_stage, clear_execution_stage,
             stall_count, fsm_state
   );

   // Pipeline side: raises events, obeys stall/clear controls.
   modport slave (
      output pc_valid, imem_ready, dmem_busy, load_use_hazard, branch_taken, jump_decode,
      input  stall_programe_counter_stage, stall_instruction_fetch_stage,
             stall_decoding_stage, stall_execution_stage,
             clear_instruction_fetch_stage, clear_decoding_stage, clear_execution_stage,
             stall_count, fsm_state
   );
endinterface

// File: rtl/pipeline_flow_controller.sv
// Pipeline flow controller: resolves memory stalls, branch/jump redirects and
// load-use hazards into per-stage stall/clear controls. State, flush counter
// and stall counter are registered; the controls are combinational.
module pipeline_flow_controller #(
   parameter int unsigned FLUSH_CYCLES = 1
) (
   input logic                      clk,
   input logic                      rst_n,
   pipeline_flow_controller_if.master bus
);

   typedef enum logic [1:0] {
      RUN       = 2'b00,
      IMEM_WAIT = 2'b01,
      DMEM_WAIT = 2'b10,
      FLUSH     = 2'b11
   } state_e;

   typedef struct packed {
      logic stall_pc;
      logic stall_if;
      logic stall_de;
      logic stall_ex;
      logic clear_if;
      logic clear_de;
      logic clear_ex;
   } ctrl_t;

   // Remaining flush cycles after the redirect cycle itself.
   localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

   state_e      state_q, state_d;
   logic [2:0]  flush_cnt_q, flush_cnt_d;
   logic [15:0] stall_count_q;
   ctrl_t       ctrl;
   logic        imem_miss;
   logic        flush_pending;
   state_e      wait_exit;

   assign imem_miss     = bus.pc_valid & ~bus.imem_ready;
   // A memory wait that interrupted a flush must resume it on exit.
   assign flush_pending = (state_q == DMEM_WAIT) && (flush_cnt_q != 3'd0);
   assign wait_exit     = flush_pending ? FLUSH : RUN;

   // Priority resolution of pipeline events into controls and next state.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      ctrl        = '0;
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;

      if (bus.dmem_busy) begin
         // Freeze the whole pipeline; the flush counter keeps its value.
         ctrl.stall_pc = 1'b1;
         ctrl.stall_if = 1'b1;
         ctrl.stall_de = 1'b1;
         ctrl.stall_ex = 1'b1;
         state_d       = DMEM_WAIT;
      end else if (bus.branch_taken) begin
         ctrl.clear_if = 1'b1;
         ctrl.clear_de = 1'b1;
         flush_cnt_d   = FLUSH_RELOAD;
         state_d       = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      end else begin
         case (state_q)
            FLUSH: begin
               // Wrong-path fetch/decode are discarded; decode-side events
               // and fetch misses are irrelevant while flushing.
               ctrl.clear_if = 1'b1;
               ctrl.clear_de = 1'b1;
               flush_cnt_d   = (flush_cnt_q != 3'd0) ? flush_cnt_q - 3'd1 : 3'd0;
               state_d       = (flush_cnt_q > 3'd1) ? FLUSH : RUN;
            end
            default: begin
               // RUN, IMEM_WAIT and the DMEM_WAIT exit cycle share the
               // lower-priority event handling.
               if (bus.load_use_hazard) begin
                  ctrl.stall_pc = 1'b1;
                  ctrl.stall_if = 1'b1;
                  ctrl.stall_de = 1'b1;
                  ctrl.clear_ex = 1'b1;
                  if (state_q == DMEM_WAIT) begin
                     state_d = wait_exit;
                  end
               end else if (imem_miss) begin
                  ctrl.stall_pc = 1'b1;
                  ctrl.stall_if = 1'b1;
                  ctrl.clear_de = 1'b1;
                  state_d       = flush_pending ? FLUSH : IMEM_WAIT;
               end else begin
                  if (bus.jump_decode && (state_q != IMEM_WAIT)) begin
                     ctrl.clear_if = 1'b1;
                  end
                  state_d = wait_exit;
               end
            end
         endcase
      end
   end

   // State and flush counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         state_q     <= RUN;
         flush_cnt_q <= 3'd0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Saturating count of cycles in which the PC is held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count_q <= 16'd0;
      end else if (ctrl.stall_pc && (stall_count_q != 16'hFFFF)) begin
         stall_count_q <= stall_count_q + 16'd1;
      end
   end

   assign bus.stall_programe_counter_stage  = ctrl.stall_pc;
   assign bus.stall_instruction_fetch_stage = ctrl.stall_if;
   assign bus.stall_decoding_stage          = ctrl.stall_de;
   assign bus.stall_execution_stage         = ctrl.stall_ex;
   assign bus.clear_instruction_fetch_stage = ctrl.clear_if;
   assign bus.clear_decoding_stage          = ctrl.clear_de;
   assign bus.clear_execution_stage         = ctrl.clear_ex;
   assign bus.stall_count                   = stall_count_q;
   assign bus.fsm_state                     = state_q;

endmodule

// File: tb/tb_pipeline_flow_controller.sv
// Directed self-checking bench for pipeline_flow_controller (FLUSH_CYCLES=3).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
module tb_pipeline_flow_controller;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   pipeline_flow_controller_if bus ();

   pipeline_flow_controller #(.FLUSH_CYCLES(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   // Input vector order: {pc_valid, imem_ready, dmem_busy, load_use_hazard, branch_taken, jump_decode}
   task automatic set_in(input logic [5:0] v);
      {bus.pc_valid, bus.imem_ready, bus.dmem_busy,
       bus.load_use_hazard, bus.branch_taken, bus.jump_decode} = v;
   endtask

   // Compare {fsm_state, stall pc/if/de/ex, clear if/de/ex}.
   task automatic chk_out(input string tag, input logic [1:0] st,
                          input logic [3:0] stl, input logic [2:0] clr);
      logic [8:0] obs;
      logic [8:0] exp;
      obs = {bus.fsm_state,
             bus.stall_programe_counter_stage, bus.stall_instruction_fetch_stage,
             bus.stall_decoding_stage, bus.stall_execution_stage,
             bus.clear_instruction_fetch_stage, bus.clear_decoding_stage,
             bus.clear_execution_stage};
      exp = {st, stl, clr};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed st/stall/clear=%b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_cnt(input string tag, input logic [15:0] exp);
      checks++;
      assert (bus.stall_count === exp) else begin
         errors++;
         $error("FAIL %s: observed stall_count=%h expected %h", tag, bus.stall_count, exp);
      end
   endtask

   // One cycle: apply inputs, check at falling edge, advance past rising edge.
   task automatic step(input string tag, input logic [5:0] v, input logic [1:0] st,
                       input logic [3:0] stl, input logic [2:0] clr);
      set_in(v);
      @(negedge clk);
      chk_out(tag, st, stl, clr);
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      set_in(6'b000000);
      #2;
      chk_out("reset_outputs", 2'b00, 4'b0000, 3'b000);
      chk_cnt("reset_count", 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Idle after reset
      for (int i = 0; i < 10; i++) step("idle", 6'b000000, 2'b00, 4'b0000, 3'b000);
      chk_cnt("idle_count", 16'h0000);

      // Instruction memory miss for 3 cycles, then data returns
      step("imiss_run",   6'b100000, 2'b00, 4'b1100, 3'b010);
      step("imiss_wait1", 6'b100000, 2'b01, 4'b1100, 3'b010);
      step("imiss_wait2", 6'b100000, 2'b01, 4'b1100, 3'b010);
      step("imiss_ready", 6'b110000, 2'b01, 4'b0000, 3'b000);
      step("imiss_done",  6'b000000, 2'b00, 4'b0000, 3'b000);
      chk_cnt("imiss_count", 16'd3);

      // Branch with a 3-cycle flush
      step("br_take",   6'b000010, 2'b00, 4'b0000, 3'b110);
      step("br_flush1", 6'b000000, 2'b11, 4'b0000, 3'b110);
      step("br_flush2", 6'b000000, 2'b11, 4'b0000, 3'b110);
      step("br_done",   6'b000000, 2'b00, 4'b0000, 3'b000);

      // Branch, data memory busy 4 cycles interrupting the flush
      step("bd_take",   6'b000010, 2'b00, 4'b0000, 3'b110);
      step("bd_flush1", 6'b000000, 2'b11, 4'b0000, 3'b110);
      step("bd_busy1",  6'b001000, 2'b11, 4'b1111, 3'b000);
      step("bd_busy2",  6'b001000, 2'b10, 4'b1111, 3'b000);
      step("bd_busy3",  6'b001000, 2'b10, 4'b1111, 3'b000);
      step("bd_busy4",  6'b001000, 2'b10, 4'b1111, 3'b000);
      step("bd_exit",   6'b000000, 2'b10, 4'b0000, 3'b000);
      step("bd_resume", 6'b000000, 2'b11, 4'b0000, 3'b110);
      step("bd_done",   6'b000000, 2'b00, 4'b0000, 3'b000);
      chk_cnt("bd_count", 16'd7);

      // Branch beats load-use and jump; decode events ignored during flush
      step("pri_all",    6'b000111, 2'b00, 4'b0000, 3'b110);
      step("pri_flush1", 6'b000101, 2'b11, 4'b0000, 3'b110);
      step("pri_flush2", 6'b000101, 2'b11, 4'b0000, 3'b110);
      step("pri_done",   6'b000000, 2'b00, 4'b0000, 3'b000);
      step("luh_only",   6'b000100, 2'b00, 4'b1110, 3'b001);
      step("luh_done",   6'b000000, 2'b00, 4'b0000, 3'b000);
      step("jump_only",  6'b000001, 2'b00, 4'b0000, 3'b100);
      step("jump_done",  6'b000000, 2'b00, 4'b0000, 3'b000);
      chk_cnt("luh_count", 16'd8);

      // Reset in the middle of a flush abandons it
      step("rf_take", 6'b000010, 2'b00, 4'b0000, 3'b110);
      set_in(6'b000000);
      @(negedge clk);
      chk_out("rf_flush", 2'b11, 4'b0000, 3'b110);
      #1;
      rst_n = 1'b0;
      #1;
      chk_out("rf_reset", 2'b00, 4'b0000, 3'b000);
      chk_cnt("rf_reset_count", 16'h0000);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      step("rf_after", 6'b000000, 2'b00, 4'b0000, 3'b000);

      // Long data memory stall saturates the counter, then async reset
      set_in(6'b001000);
      repeat (70000) @(posedge clk);
      @(negedge clk);
      chk_cnt("sat_count", 16'hFFFF);
      chk_out("sat_state", 2'b10, 4'b1111, 3'b000);
      #2;
      rst_n = 1'b0;
      #1;
      chk_out("sat_reset", 2'b00, 4'b1111, 3'b000);
      chk_cnt("sat_reset_count", 16'h0000);
      set_in(6'b000000);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      step("sat_after", 6'b000000, 2'b00, 4'b0000, 3'b000);
      chk_cnt("sat_after_count", 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipeline_flow_controller.md
PIPELINE_FLOW_CONTROLLER -- requirements
Module: pipeline_flow_controller

Interface
REQ-001 Parameter FLUSH_CYCLES, default 1, number of cycles (1..7) for which IF and DE are cleared after a taken branch.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST_N  input  1  asynchronous, active-low reset.
REQ-004 PC_VALID  input  1  PC stage is presenting a valid fetch address this cycle.
REQ-005 IMEM_READY  input  1  instruction memory returns data for the presented PC this cycle.
REQ-006 DMEM_BUSY  input  1  data memory cannot accept or complete an access this cycle.
REQ-007 LOAD_USE_HAZARD  input  1  decode instruction needs the result of a load currently in execution.
REQ-008 BRANCH_TAKEN  input  1  execution stage redirects the PC (branch taken, JALR).
REQ-009 JUMP_DECODE  input  1  decode stage redirects the PC (JAL).
REQ-010 STALL_PROGRAME_COUNTER_STAGE  output  1  hold PC.
REQ-011 STALL_INSTRUCTION_FETCH_STAGE, STALL_DECODING_STAGE, STALL_EXECUTION_STAGE  output  1 each  hold the named pipeline register.
REQ-012 CLEAR_INSTRUCTION_FETCH_STAGE, CLEAR_DECODING_STAGE, CLEAR_EXECUTION_STAGE  output  1 each  load a bubble into the named pipeline register.
REQ-013 STALL_COUNT  output  16  saturating count of cycles with STALL_PROGRAME_COUNTER_STAGE=1.
REQ-014 FSM_STATE  output  2  current state encoding.

Function
REQ-015 States: RUN=00, IMEM_WAIT=01, DMEM_WAIT=10, FLUSH=11. State, flush counter (3 bit) and STALL_COUNT are registered; all stall/clear outputs are combinational from current state and inputs.
REQ-016 Event priority, highest first, in every state: DMEM_BUSY, BRANCH_TAKEN, LOAD_USE_HAZARD, IMEM miss (PC_VALID=1 and IMEM_READY=0), JUMP_DECODE; only the highest active event acts in a cycle.
REQ-017 DMEM_BUSY=1: assert all four STALL outputs, no CLEAR; next state DMEM_WAIT; flush counter frozen.
REQ-018 DMEM_WAIT with DMEM_BUSY=0: next state FLUSH if flush counter nonzero, else RUN; outputs that cycle follow the lower-priority events per REQ-016.
REQ-019 BRANCH_TAKEN=1 (DMEM_BUSY=0): assert CLEAR_INSTRUCTION_FETCH_STAGE and CLEAR_DECODING_STAGE, no STALL outputs; load flush counter with FLUSH_CYCLES-1; next state FLUSH if FLUSH_CYCLES>1, else RUN.
REQ-020 FLUSH: assert CLEAR_INSTRUCTION_FETCH_STAGE and CLEAR_DECODING_STAGE, decrement counter; exit to RUN in the cycle the counter is 1; LOAD_USE_HAZARD and JUMP_DECODE ignored in FLUSH.
REQ-021 LOAD_USE_HAZARD (RUN or IMEM_WAIT): assert STALL_PROGRAME_COUNTER_STAGE, STALL_INSTRUCTION_FETCH_STAGE, STALL_DECODING_STAGE and CLEAR_EXECUTION_STAGE; state unchanged.
REQ-022 IMEM miss: assert STALL_PROGRAME_COUNTER_STAGE, STALL_INSTRUCTION_FETCH_STAGE and CLEAR_DECODING_STAGE; next state IMEM_WAIT.
REQ-023 IMEM_WAIT exits to RUN in the cycle IMEM_READY=1; outputs that cycle are all deasserted unless another event is active.
REQ-024 JUMP_DECODE (RUN only, no higher event): assert CLEAR_INSTRUCTION_FETCH_STAGE for that cycle only.
REQ-025 A STALL and a CLEAR are never both asserted on the same stage register.
REQ-026 STALL_COUNT increments on each edge where STALL_PROGRAME_COUNTER_STAGE=1; holds at 16'hFFFF.
REQ-027 FLUSH_CYCLES outside 1..7 is a configuration error; behaviour is undefined.

Reset
REQ-028 RST_N=0 forces, asynchronously: state RUN, flush counter 0, STALL_COUNT 0, FSM_STATE 00; with inputs idle, all STALL/CLEAR outputs 0.
REQ-029 Reset asserted mid-FLUSH, mid-IMEM_WAIT or mid-DMEM_WAIT abandons the operation; the first edge after release evaluates from RUN.

Verification
REQ-030 Reset release, all inputs 0 for 10 cycles -> FSM_STATE=00, all STALL/CLEAR 0, STALL_COUNT=0.
REQ-031 PC_VALID=1, IMEM_READY=0 for 3 cycles then 1 -> IMEM_WAIT for 3 cycles with PC/IF stall and DE clear, RUN after, STALL_COUNT=3.
REQ-032 FLUSH_CYCLES=3, BRANCH_TAKEN pulse 1 cycle -> IF/DE clear for 3 consecutive cycles, FSM_STATE 11 for 2 cycles, then 00.
REQ-033 FLUSH_CYCLES=3, branch, then DMEM_BUSY for 4 cycles during the 2nd flush cycle -> all stalls for 4 cycles, then FLUSH resumes with 1 remaining clear cycle, then RUN.
REQ-034 LOAD_USE_HAZARD, JUMP_DECODE and BRANCH_TAKEN together -> only IF/DE clear (branch wins); LOAD_USE_HAZARD alone -> PC/IF/DE stall with EX clear, 1 cycle.
REQ-035 DMEM_BUSY held 70000 cycles -> STALL_COUNT saturates at 16'hFFFF; assert RST_N=0 mid-run -> immediate return to FSM_STATE 00, STALL_COUNT 0.
